// File: rtl/mul16_seq_ctrl.sv
// Sequential unsigned 16x16 shift-and-add multiplier controller.
// Drives a shared external 16-bit adder once per clock for 16 clocks.
module mul16_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] mcand,
  input  logic [15:0] mplier,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_cin,
  input  logic [15:0] add_y,
  input  logic        add_cout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [15:0] mc_q;
  logic [15:0] hi_q;
  logic [15:0] lo_q;
  logic [31:0] product_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] acc_d;

  // The adder carry-out becomes the new MSB so nothing is lost on the right shift.
  assign acc_d = {add_cout, add_y, lo_q[15:1]};

  always_comb begin
    add_a   = 16'h0000;
    add_b   = 16'h0000;
    add_cin = 1'b0;
    if (state_q == RUN) begin
      add_a = hi_q;
      add_b = lo_q[0] ? mc_q : 16'h0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      mc_q      <= 16'h0000;
      hi_q      <= 16'h0000;
      lo_q      <= 16'h0000;
      product_q <= 32'h0000_0000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (start) begin
            mc_q    <= mcand;
            lo_q    <= mplier;
            hi_q    <= 16'h0000;
            cnt_q   <= 4'd0;
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          {hi_q, lo_q} <= acc_d;
          cnt_q        <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_q   <= DONE;
            product_q <= acc_d;
            done_q    <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_mul16_seq_ctrl.sv
// Directed bench for mul16_seq_ctrl with a behavioural model of the external adder.
module tb_mul16_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] mcand = 16'h0000;
  logic [15:0] mplier = 16'h0000;
  logic        busy, done, add_cin, add_cout;
  logic [31:0] product;
  logic [15:0] add_a, add_b, add_y;
  logic [16:0] sum17;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign sum17 = {1'b0, add_a} + {1'b0, add_b} + {16'h0000, add_cin};
  assign add_y = sum17[15:0];
  assign add_cout = sum17[16];

  mul16_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .mcand(mcand), .mplier(mplier),
    .busy(busy), .done(done), .product(product),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_y(add_y), .add_cout(add_cout)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int c = 0;
    while (busy !== 1'b0 && c < 40) begin
      tick();
      c++;
    end
    check({nm, "/idle_wait"}, {31'd0, busy}, 32'd0);
  endtask

  // One operation; when noisy, inputs and start are scrambled during RUN.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp, input string nm, input bit noisy);
    int bad_b = 0;
    int bad_ctl = 0;
    logic [15:0] expb;
    wait_idle(nm);
    mcand = a;
    mplier = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      expb = b[k] ? a : 16'h0000;
      if (add_b !== expb) bad_b++;
      if (busy !== 1'b1 || done !== 1'b0 || add_cin !== 1'b0) bad_ctl++;
      if (noisy) begin
        mcand = 16'($urandom);
        mplier = 16'($urandom);
        start = (k % 2) == 1;
      end
      tick();
    end
    start = 1'b0;
    check({nm, "/run_add_b_errs"}, 32'(bad_b), 32'd0);
    check({nm, "/run_ctl_errs"}, 32'(bad_ctl), 32'd0);
    check({nm, "/done"}, {31'd0, done}, 32'd1);
    check({nm, "/busy_in_done"}, {31'd0, busy}, 32'd1);
    check({nm, "/product"}, product, exp);
    check({nm, "/add_b_idle"}, {16'd0, add_b}, 32'd0);
    tick();
    check({nm, "/done_after"}, {31'd0, done}, 32'd0);
    check({nm, "/busy_after"}, {31'd0, busy}, 32'd0);
    check({nm, "/product_hold"}, product, exp);
  endtask

  initial begin
    vec_t vecs[10];
    int done_at[$];
    vecs[0] = '{16'h0003, 16'h0005, 32'h0000_000F};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
    vecs[2] = '{16'h1234, 16'h0000, 32'h0000_0000};
    vecs[3] = '{16'h0000, 16'hABCD, 32'h0000_0000};
    vecs[4] = '{16'h0010, 16'h0010, 32'h0000_0100};
    vecs[5] = '{16'h8000, 16'h0002, 32'h0001_0000};
    vecs[6] = '{16'hFFFF, 16'h0001, 32'h0000_FFFF};
    vecs[7] = '{16'h0001, 16'hFFFF, 32'h0000_FFFF};
    vecs[8] = '{16'hABCD, 16'h1234, 32'h0C37_4FA4};
    vecs[9] = '{16'h00FF, 16'h0100, 32'h0000_FF00};

    repeat (3) tick();
    check("reset/busy", {31'd0, busy}, 32'd0);
    check("reset/done", {31'd0, done}, 32'd0);
    check("reset/product", product, 32'd0);
    check("reset/add_a", {16'd0, add_a}, 32'd0);
    check("reset/add_b", {16'd0, add_b}, 32'd0);
    check("reset/add_cin", {31'd0, add_cin}, 32'd0);
    rst = 1'b0;
    tick();
    check("idle/no_start_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i), (i % 2) == 1);

    // start held high: back-to-back operations every 18 cycles
    wait_idle("held");
    mcand = 16'h00FF;
    mplier = 16'h0100;
    start = 1'b1;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (done === 1'b1) begin
        done_at.push_back(c);
        check("held/product", product, 32'h0000_FF00);
      end
    end
    start = 1'b0;
    check("held/pulse_count", 32'(done_at.size()), 32'd3);
    check("held/first_latency", (done_at.size() > 0) ? 32'(done_at[0]) : 32'hFFFF_FFFF, 32'd16);
    for (int j = 1; j < done_at.size(); j++)
      check("held/period", 32'(done_at[j] - done_at[j-1]), 32'd18);

    // reset during RUN cycle 7
    wait_idle("midrst");
    mcand = 16'h1234;
    mplier = 16'h5678;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    check("midrst/busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst/busy", {31'd0, busy}, 32'd0);
    check("midrst/done", {31'd0, done}, 32'd0);
    check("midrst/product", product, 32'd0);
    check("midrst/add_b", {16'd0, add_b}, 32'd0);
    repeat (20) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) break;
    end
    check("midrst/stays_idle", {30'd0, busy, done}, 32'd0);
    run_op(16'h0007, 16'h0009, 32'h0000_003F, "after_rst", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
